mem_port_unit: RTL
==================

# mem_port_unit

Memory port between the multicycle control FSM and an external 16-bit word memory. Takes the one-cycle `MemRead`/`MemWrite`/`IorD`/`IRWrite` strobes from control, runs a `mem_req`/`mem_ack` handshake, and captures read data into the instruction register (`inst`, which feeds control) and the memory data register (`MDR`). It also flags protocol errors and memory timeouts.

## Interface
- `TIMEOUT`, default 15: maximum number of cycles `mem_req` is held waiting for `mem_ack`. Legal range 1..255.
- `CLK` in 1: single clock; everything updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `MemRead` in 1: read strobe from control, one cycle wide.
- `MemWrite` in 1: write strobe from control, one cycle wide.
- `IorD` in 1: address select. 0 selects `PC`, 1 selects `ALUOut`.
- `IRWrite` in 1: when high with `MemRead`, the read data also loads `inst`.
- `PC` in 16: instruction address.
- `ALUOut` in 16: data address.
- `WriteData` in 16: store data (B register).
- `mem_rdata` in 16: memory read data, valid when `mem_ack` is high.
- `mem_ack` in 1: memory completion.
- `mem_req` out 1: request, held high until ack or timeout.
- `mem_we` out 1: 1 = write, 0 = read. Valid while `mem_req` is high.
- `mem_addr` out 16: latched address.
- `mem_wdata` out 16: latched store data.
- `inst` out 16: instruction register.
- `MDR` out 16: memory data register.
- `Busy` out 1: a transaction is outstanding.
- `MemErr` out 1: sticky error flag, cleared only by `Reset`.

## Operation
- The FSM has two states, IDLE and REQ. The state and all outputs are registered.
- **IDLE:**
  - On an edge with `MemRead` or `MemWrite` high, the unit latches:
    - `mem_addr` from `IorD ? ALUOut : PC`;
    - `mem_wdata` from `WriteData`;
    - `mem_we` from `MemWrite`;
    - an internal `ir_load` flag from `IRWrite & MemRead & ~MemWrite`.
  - It then moves to REQ, with `mem_req`=1, `Busy`=1 and the timeout counter cleared to 0.
- **Read and write together:** if `MemRead` and `MemWrite` are both high, the unit performs the write, sets `MemErr`, and no register loads.
- **REQ, acked:** on an edge with `mem_ack`=1:
  - For a read, `MDR` <= `mem_rdata`, and `inst` <= `mem_rdata` if `ir_load` is set.
  - For a write, no register loads.
  - The unit returns to IDLE with `mem_req`=0 and `Busy`=0.
- **REQ, not acked:** on an edge with `mem_ack`=0:
  - If counter == `TIMEOUT`-1, the transaction aborts: return to IDLE, `mem_req`=0, `Busy`=0, `MemErr`=1, and `inst`/`MDR` are unchanged.
  - Otherwise the counter increments.
- **Strobe while busy:** a `MemRead` or `MemWrite` strobe arriving while in REQ is dropped and sets `MemErr`. The transaction in flight is unaffected.
- **Stray ack:** `mem_ack` while in IDLE is ignored and does not set an error.
- **Held signals:** `mem_addr`, `mem_wdata` and `mem_we` hold their values in IDLE until the next accepted request.
- **Address width:** addresses pass through unmodified (16-bit word address, no arithmetic).

## Timing
- **Reset values:**
  - `mem_req`, `mem_we`, `Busy`, `MemErr` = 0;
  - `mem_addr`, `mem_wdata`, `inst`, `MDR` = 16'h0000;
  - state = IDLE, counter = 0.
- **Reset mid-transaction:** the transaction is abandoned and the unit is in IDLE after that edge; `mem_req` is low in the following cycle. A late `mem_ack` is then ignored.
- **Read latency:** strobe sampled at edge t0 → `mem_req` high in cycle t0..t1 → ack sampled at edge tN → `inst`/`MDR` valid in cycle tN onward.
  - With zero-wait memory (ack in the first REQ cycle), data is valid 2 edges after the strobe.
- **Timeout:** `mem_req` is high for at most `TIMEOUT` cycles. An ack in the `TIMEOUT`th cycle still completes successfully.
- **Back-to-back:** a new strobe is accepted on the edge where `Busy` has already been low for that cycle.
  - The strobe may coincide with the cycle after completion, but not with the completing edge itself; such a strobe is dropped and sets `MemErr`.
- **Control FSM pacing:** control FSM sequencing must allow at least one REQ cycle before consuming `inst`/`MDR`.

## Test plan
- **Zero-wait instruction fetch.**
  - Stimulus: `Reset`, then `PC`=16'h0010, `IorD`=0, `MemRead`=`IRWrite`=1 for one cycle; memory acks immediately with 16'hA5B8.
  - Required: `mem_addr`=16'h0010, `mem_req` high exactly 1 cycle, then `inst`=`MDR`=16'hA5B8, `Busy`=0, `MemErr`=0.
- **Wait-state load.**
  - Stimulus: `IorD`=1, `ALUOut`=16'h0200, `MemRead`=1, `IRWrite`=0; ack after 4 cycles with 16'h1234.
  - Required: `mem_req` high 4 cycles, `MDR`=16'h1234, `inst` unchanged.
- **Store.**
  - Stimulus: `MemWrite`=1, `ALUOut`=16'h0300, `WriteData`=16'hBEEF; ack after 2 cycles.
  - Required: `mem_we`=1, `mem_wdata`=16'hBEEF; `MDR` and `inst` unchanged.
- **Timeout, `TIMEOUT`=15.**
  - Stimulus: a read with no ack.
  - Required: `mem_req` high exactly 15 cycles, then `MemErr`=1 and `inst`/`MDR` unchanged.
  - Variant: a second run with ack in cycle 15 completes with `MemErr`=0.
- **Protocol errors.**
  - Stimulus: a `MemRead` strobe during REQ; separately, `MemRead`+`MemWrite` together.
  - Required: `MemErr`=1 in both cases. The in-flight transaction completes normally; the dual strobe performs a write only.
- **Reset mid-operation.**
  - Stimulus: assert `Reset` on the 2nd REQ cycle, then ack one cycle later.
  - Required: all outputs return to their reset values and the late ack is ignored.

Source files
------------

// File: rtl/mem_port_unit.sv
// mem_port_unit: request/acknowledge memory port for a multicycle datapath.
// Accepts one-cycle read/write strobes from the control FSM, latches the
// address and store data, holds mem_req until mem_ack or a timeout, and
// captures read data into MDR and (for fetches) the instruction register.
// MemErr is a sticky flag for protocol violations and memory timeouts.
module mem_port_unit #(
   parameter int TIMEOUT = 15
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        IorD,
   input  logic        IRWrite,
   input  logic [15:0] PC,
   input  logic [15:0] ALUOut,
   input  logic [15:0] WriteData,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic [15:0] inst,
   output logic [15:0] MDR,
   output logic        Busy,
   output logic        MemErr
);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   // Counter value on which an unacknowledged request gives up; with the
   // counter cleared on entry, this bounds mem_req to TIMEOUT cycles.
   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        ir_load_q, ir_load_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] inst_q, inst_d;
   logic [15:0] mdr_q, mdr_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;

   logic strobe;
   assign strobe = MemRead | MemWrite;

   // State and output registers, all cleared by a synchronous Reset.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         ir_load_q <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 16'h0000;
         wdata_q   <= 16'h0000;
         inst_q    <= 16'h0000;
         mdr_q     <= 16'h0000;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ir_load_q <= ir_load_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         inst_q    <= inst_d;
         mdr_q     <= mdr_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   // Next state: leave IDLE on any strobe, leave REQ on ack or timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (strobe) state_d = REQ;
         REQ:     if (mem_ack || (cnt_q == LAST_CNT)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs, counter and fetch flag.
   always_comb begin
      cnt_d     = cnt_q;
      ir_load_d = ir_load_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      inst_d    = inst_q;
      mdr_d     = mdr_q;
      busy_d    = busy_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            // mem_ack here is a stray ack and is deliberately ignored.
            if (strobe) begin
               addr_d    = IorD ? ALUOut : PC;
               wdata_d   = WriteData;
               we_d      = MemWrite;          // dual strobe resolves to a write
               ir_load_d = IRWrite & MemRead & ~MemWrite;
               req_d     = 1'b1;
               busy_d    = 1'b1;
               cnt_d     = 8'd0;
               if (MemRead && MemWrite) err_d = 1'b1;
            end
         end
         REQ: begin
            // A strobe here (including on the completing edge) is dropped.
            if (strobe) err_d = 1'b1;
            if (mem_ack) begin
               if (!we_q) begin
                  mdr_d = mem_rdata;
                  if (ir_load_q) inst_d = mem_rdata;
               end
               req_d  = 1'b0;
               busy_d = 1'b0;
            end else if (cnt_q == LAST_CNT) begin
               req_d  = 1'b0;
               busy_d = 1'b0;
               err_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: ;
      endcase
   end

   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign inst      = inst_q;
   assign MDR       = mdr_q;
   assign Busy      = busy_q;
   assign MemErr    = err_q;

endmodule
